// File: rtl/tropical_alu_pipe_if.sv
// Handshake and data bundle between the register-file read stage, the
// tropical ALU pipeline and write-back.
interface tropical_alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             err;
  logic [CNT_W-1:0] mac_cnt;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, ovf, err, mac_cnt
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, ovf, err, mac_cnt
  );
endinterface

// File: rtl/tropical_alu_pipe.sv
// Two-stage min-plus ALU with a tropical multiply-accumulate register,
// selectable overflow policy and valid/ready backpressure.
module tropical_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SAT   = 1,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  tropical_alu_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_TADD   = 3'd2,
    OP_ILL3   = 3'd3,
    OP_TMUL   = 3'd4,
    OP_TMAC   = 3'd5,
    OP_ACC_RD = 3'd6,
    OP_ILL7   = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0] INF = '1;

  // Tropical addition: min of finite values, infinity is the identity.
  function automatic logic [WIDTH-1:0] tadd(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    if (x[WIDTH-1] && y[WIDTH-1])      r = INF;
    else if (x[WIDTH-1])               r = y;
    else if (y[WIDTH-1])               r = x;
    else if (x[WIDTH-2:0] <= y[WIDTH-2:0]) r = x;
    else                               r = y;
    return r;
  endfunction

  logic             advance;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_res;
  logic             s1_ovf;
  logic             s1_err;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             err_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] mac_cnt_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] prod;
  logic             prod_ovf;
  logic [WIDTH-1:0] s1_res_d;
  logic             s1_ovf_d;
  logic             s1_err_d;

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Finite parts are WIDTH-1 bits, so their sum carries into the flag bit.
  assign sum = {1'b0, bus.a[WIDTH-2:0]} + {1'b0, bus.b[WIDTH-2:0]};

  always_comb begin
    prod     = sum;
    prod_ovf = 1'b0;
    if (bus.a[WIDTH-1] || bus.b[WIDTH-1]) begin
      prod = INF;
    end else if (sum[WIDTH-1]) begin
      prod_ovf = 1'b1;
      prod     = (SAT != 0) ? INF : {1'b0, sum[WIDTH-2:0]};
    end
  end

  // Stage 1: everything that does not depend on the accumulator.
  always_comb begin
    s1_res_d = '0;
    s1_ovf_d = 1'b0;
    s1_err_d = 1'b0;
    case (op_e'(bus.op))
      OP_AND:  s1_res_d = bus.a & bus.b;
      OP_OR:   s1_res_d = bus.a | bus.b;
      OP_TADD: s1_res_d = tadd(bus.a, bus.b);
      OP_TMUL, OP_TMAC: begin
        s1_res_d = prod;
        s1_ovf_d = prod_ovf;
      end
      OP_ACC_RD: s1_res_d = '0;
      default:   s1_err_d = 1'b1;
    endcase
  end

  // Stage 2: accumulator read/update; TMAC carries the product in s1_res.
  always_comb begin
    acc_d = acc;
    cnt_d = mac_cnt_q;
    res_d = s1_res;
    case (s1_op)
      OP_TMAC: begin
        acc_d = tadd(acc, s1_res);
        res_d = acc_d;
        cnt_d = (mac_cnt_q == '1) ? mac_cnt_q : mac_cnt_q + CNT_W'(1);
      end
      OP_ACC_RD: begin
        res_d = acc;
        acc_d = INF;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_op       <= OP_AND;
      s1_res      <= '0;
      s1_ovf      <= 1'b0;
      s1_err      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      acc         <= INF;
      mac_cnt_q   <= '0;
    end else if (advance) begin
      s1_valid    <= bus.in_valid;
      out_valid_q <= s1_valid;
      if (bus.in_valid) begin
        s1_op  <= op_e'(bus.op);
        s1_res <= s1_res_d;
        s1_ovf <= s1_ovf_d;
        s1_err <= s1_err_d;
      end
      if (s1_valid) begin
        result_q  <= res_d;
        ovf_q     <= s1_ovf;
        err_q     <= s1_err;
        acc       <= acc_d;
        mac_cnt_q <= cnt_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign bus.mac_cnt   = mac_cnt_q;

endmodule

// File: tb/tb_tropical_alu_pipe.sv
// Bench for tropical_alu_pipe: saturating and wrapping instances share one
// stimulus stream and are compared against an in-order expectation queue.
module tb_tropical_alu_pipe;

  localparam int W  = 32;
  localparam int CW = 8;
  localparam logic [31:0] INF = 32'hFFFF_FFFF;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [2:0]  op        = 3'd0;
  logic [31:0] a         = '0;
  logic [31:0] b         = '0;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_stall = -1;
  bit front_seen = 1'b0;
  bit rnd_ready  = 1'b0;

  tropical_alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();
  tropical_alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.op        = op;
  assign bus1.a         = a;
  assign bus1.b         = b;
  assign bus1.out_ready = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.op        = op;
  assign bus0.a         = a;
  assign bus0.b         = b;
  assign bus0.out_ready = out_ready;

  tropical_alu_pipe #(.WIDTH(W), .SAT(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  tropical_alu_pipe #(.WIDTH(W), .SAT(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct {
    logic [31:0] r1, r0;
    logic        o1, o0, e;
    logic [7:0]  cnt;
    int          acc_cyc;
    bit          lit;
    logic [31:0] l1, l0;
    logic        lo1, lo0, le;
    logic [7:0]  lcnt;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  logic [31:0] m_acc1 = INF;
  logic [31:0] m_acc0 = INF;
  int          m_cnt  = 0;

  bit          p_lit = 1'b0;
  logic [31:0] p_l1, p_l0;
  logic        p_lo1, p_lo0, p_le;
  logic [7:0]  p_lcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model values: bit 31 set means infinity, finite part is a plain integer.
  function automatic logic [32:0] m_tmul(input logic [31:0] x, input logic [31:0] y, input bit sat);
    longint unsigned s;
    if (x >= 32'h8000_0000 || y >= 32'h8000_0000) return {1'b0, INF};
    s = longint'(x) + longint'(y);
    if (s >= 64'h8000_0000) return {1'b1, sat ? INF : 32'(s - 64'h8000_0000)};
    return {1'b0, 32'(s)};
  endfunction

  function automatic logic [31:0] m_tadd(input logic [31:0] x, input logic [31:0] y);
    bit xi = (x >= 32'h8000_0000);
    bit yi = (y >= 32'h8000_0000);
    if (xi && yi) return INF;
    if (xi) return y;
    if (yi) return x;
    return (x < y) ? x : y;
  endfunction

  task automatic accept();
    exp_t n;
    logic [32:0] p1, p0;
    n = '{default: 0};
    n.acc_cyc = cyc;
    n.lit = p_lit; n.l1 = p_l1; n.l0 = p_l0;
    n.lo1 = p_lo1; n.lo0 = p_lo0; n.le = p_le; n.lcnt = p_lcnt;
    p1 = m_tmul(a, b, 1'b1);
    p0 = m_tmul(a, b, 1'b0);
    case (op)
      3'd0: begin n.r1 = a & b; n.r0 = a & b; end
      3'd1: begin n.r1 = a | b; n.r0 = a | b; end
      3'd2: begin n.r1 = m_tadd(a, b); n.r0 = n.r1; end
      3'd4: begin n.r1 = p1[31:0]; n.o1 = p1[32]; n.r0 = p0[31:0]; n.o0 = p0[32]; end
      3'd5: begin
        m_acc1 = m_tadd(m_acc1, p1[31:0]);
        m_acc0 = m_tadd(m_acc0, p0[31:0]);
        n.r1 = m_acc1; n.o1 = p1[32]; n.r0 = m_acc0; n.o0 = p0[32];
        if (m_cnt < 255) m_cnt++;
      end
      3'd6: begin
        n.r1 = m_acc1; n.r0 = m_acc0;
        m_acc1 = INF; m_acc0 = INF; m_cnt = 0;
      end
      default: n.e = 1'b1;
    endcase
    n.cnt = 8'(m_cnt);
    q.push_back(n);
    p_lit = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", bus1.in_ready, !bus1.out_valid || out_ready);
      check("pair_handshake", {bus0.in_ready, bus0.out_valid}, {bus1.in_ready, bus1.out_valid});
      if (bus1.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", bus1.out_valid, 0);
        end else begin
          cur = q[0];
          check("result_sat", bus1.result, cur.r1);
          check("ovf_sat", bus1.ovf, cur.o1);
          check("err_sat", bus1.err, cur.e);
          check("mac_cnt_sat", bus1.mac_cnt, cur.cnt);
          check("result_wrap", bus0.result, cur.r0);
          check("ovf_wrap", bus0.ovf, cur.o0);
          check("err_wrap", bus0.err, cur.e);
          check("mac_cnt_wrap", bus0.mac_cnt, cur.cnt);
          if (cur.lit) begin
            check("lit_result_sat", bus1.result, cur.l1);
            check("lit_ovf_sat", bus1.ovf, cur.lo1);
            check("lit_result_wrap", bus0.result, cur.l0);
            check("lit_ovf_wrap", bus0.ovf, cur.lo0);
            check("lit_err", bus1.err, cur.le);
            check("lit_mac_cnt", bus1.mac_cnt, cur.lcnt);
          end
          if (!front_seen) begin
            front_seen = 1'b1;
            if (last_stall < cur.acc_cyc) check("latency", 64'(cyc - cur.acc_cyc), 2);
          end
          if (out_ready) begin
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
        if (!out_ready) last_stall = cyc;
      end
      if (in_valid && bus1.in_ready) accept();
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bit done = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus1.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", bus1.in_ready, 1);
  endtask

  task automatic issue_lit(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] l1, input logic lo1,
                           input logic [31:0] l0, input logic lo0,
                           input logic le, input logic [7:0] lcnt);
    p_lit = 1'b1; p_l1 = l1; p_lo1 = lo1; p_l0 = l0; p_lo0 = lo0; p_le = le; p_lcnt = lcnt;
    issue(o, x, y);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) break;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", {bus1.out_valid, bus0.out_valid}, 0);
    check("rst_result", {bus1.result, bus0.result}, 0);
    check("rst_flags", {bus1.ovf, bus1.err, bus0.ovf, bus0.err}, 0);
    check("rst_mac_cnt", {bus1.mac_cnt, bus0.mac_cnt}, 0);
    q.delete();
    front_seen = 1'b0;
    m_acc1 = INF; m_acc0 = INF; m_cnt = 0; p_lit = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000 | $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
      3: return INF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    do_reset();

    issue_lit(3'd2, 32'h7FFF_FFFF, 32'h1, 32'h1, 0, 32'h1, 0, 0, 8'd0);
    issue_lit(3'd2, 32'h8000_0000, INF, INF, 0, INF, 0, 0, 8'd0);
    issue_lit(3'd4, 32'h7FFF_FFFF, 32'h1, INF, 1, 32'h0, 1, 0, 8'd0);
    issue_lit(3'd4, 32'd3, 32'd4, 32'd7, 0, 32'd7, 0, 0, 8'd0);
    issue_lit(3'd4, 32'h8000_0000, 32'd5, INF, 0, INF, 0, 0, 8'd0);

    issue_lit(3'd5, 32'd3, 32'd4, 32'd7, 0, 32'd7, 0, 0, 8'd1);
    issue_lit(3'd5, 32'd1, 32'd10, 32'd7, 0, 32'd7, 0, 0, 8'd2);
    issue_lit(3'd5, 32'h8000_0000, 32'd0, 32'd7, 0, 32'd7, 0, 0, 8'd3);
    issue_lit(3'd6, 32'd0, 32'd0, 32'd7, 0, 32'd7, 0, 0, 8'd0);
    issue_lit(3'd5, 32'd2, 32'd2, 32'd4, 0, 32'd4, 0, 0, 8'd1);
    wait_drain();

    fork
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      for (int i = 0; i < 5; i++) issue(3'd2, $urandom_range(0, 1000), $urandom_range(0, 1000));
    join
    wait_drain();

    issue_lit(3'd3, 32'd5, 32'd6, 32'd0, 0, 32'd0, 0, 1, 8'd1);
    issue_lit(3'd7, INF, INF, 32'd0, 0, 32'd0, 0, 1, 8'd1);
    issue_lit(3'd6, 32'd0, 32'd0, 32'd4, 0, 32'd4, 0, 0, 8'd0);
    wait_drain();

    issue(3'd5, 32'd5, 32'd5);
    issue(3'd5, 32'd1, 32'd1);
    @(posedge clk);
    #1;
    check("pre_reset_busy", bus1.out_valid, 1);
    do_reset();
    issue_lit(3'd6, 32'd0, 32'd0, INF, 0, INF, 0, 0, 8'd0);
    wait_drain();

    for (int i = 0; i < 258; i++) issue(3'd5, $urandom_range(0, 5000), $urandom_range(0, 5000));
    wait_drain();
    check("mac_cnt_saturated", bus1.mac_cnt, 8'hFF);
    issue(3'd6, 32'd0, 32'd0);
    wait_drain();
    check("mac_cnt_cleared", bus1.mac_cnt, 8'h00);

    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/tropical_alu_pipe.md
Name: tropical_alu_pipe

Overview:
Parametrised, pipelined tropical (min-plus) ALU for the TropicALU datapath. It supports the existing AND/OR/tropical-add/tropical-multiply ops at any width and adds:
- a tropical multiply-accumulate register for dot products;
- a selectable overflow policy;
- valid/ready handshaking with backpressure.

It sits between register-file read and write-back, replacing the single-cycle combinational ALU.

Parameters:
WIDTH, 32, operand/result width; bit WIDTH-1 is the infinity flag, bits WIDTH-2:0 are the finite unsigned value
SAT, 1, TMUL/TMAC overflow policy: 1 = saturate to infinity, 0 = wrap (clear MSB)
CNT_W, 8, width of the MAC term counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid & in_ready
op  in  3  0 AND, 1 OR, 2 TADD, 4 TMUL, 5 TMAC, 6 ACC_RD; 3 and 7 are illegal
a  in  WIDTH  operand Rs
b  in  WIDTH  operand Rt
out_valid  out  1  result available
out_ready  in  1  consumer takes result when out_valid & out_ready
result  out  WIDTH  result value
ovf  out  1  finite-sum carry occurred for this result
err  out  1  illegal op
mac_cnt  out  CNT_W  terms accumulated since the last ACC_RD

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, result=0, ovf=0, err=0, mac_cnt=0.
  - Accumulator = all-ones (canonical infinity).
  - Both pipeline stages invalid.
- Infinity: any operand with MSB=1 is infinity. Every infinity output is canonical all-ones.
- Per-op results:
  - AND, OR: bitwise, with no infinity handling.
  - TADD: min of finite values. One operand infinite -> the other operand. Both infinite -> all-ones. Equal values -> that value.
  - TMUL: either operand infinite -> all-ones, ovf=0. Otherwise sum = a[W-2:0] + b[W-2:0] computed at WIDTH bits.
    - If sum[W-1]=1: ovf=1; result = all-ones when SAT=1, or sum with MSB cleared when SAT=0.
    - Otherwise result = sum, ovf=0.
  - TMAC: p = TMUL(a,b) under the same rules. acc_next = TADD(acc, p). Result = acc_next; ovf = ovf of p. mac_cnt increments, saturating at all-ones; infinite p still counts.
  - ACC_RD: result = current acc. Then acc <= all-ones and mac_cnt <= 0 in the same edge.
  - Illegal op: result=0, err=1, no state change.
- Pipeline: two stages.
  - S1 registers the op, the operands and the TMUL/compare partials.
  - S2 performs the accumulator read/update and drives the outputs.
  - Latency: accepted at edge N -> out_valid at edge N+2 when there is no stall.
- Flow control:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance=1, S1 moves to S2 and new input loads into S1; bubbles propagate as invalid.
  - When advance=0, everything holds: result, ovf, err, out_valid and acc are stable, and nothing is dropped or duplicated.
  - Full throughput is one op per cycle while out_ready=1.
- Accumulator timing: acc and mac_cnt update only on the edge where a valid TMAC/ACC_RD moves into S2. Back-to-back TMACs therefore see each other's updates, with no hazard and no stall.
- Output ordering strictly follows acceptance order.
- Reset mid-operation discards in-flight ops and clears acc to infinity.

Test Plan:
1. TADD a=0x7FFFFFFF, b=0x00000001 -> result 0x00000001 two cycles after accept. TADD a=0x80000000, b=0xFFFFFFFF -> result 0xFFFFFFFF.
2. TMUL a=0x7FFFFFFF, b=0x00000001: with SAT=1 -> 0xFFFFFFFF, ovf=1; with SAT=0 -> 0x00000000, ovf=1. TMUL a=3, b=4 -> 7, ovf=0. TMUL a=0x80000000, b=5 -> 0xFFFFFFFF, ovf=0.
3. Back-to-back TMAC (3,4), (1,10), (0x80000000,0), then ACC_RD -> results 7, 7, 7, 7 with mac_cnt 1, 2, 3. After ACC_RD: mac_cnt=0, and the next TMAC (2,2) -> 4.
4. Stream 5 ops with out_ready=0 for cycles 3-5 -> in_ready low while held. All 5 results emerge in order, each exactly once, with result stable during the stall.
5. op=3 -> err=1, result=0, acc unchanged (a following ACC_RD returns the prior acc). Assert rst_n low mid-stream -> out_valid=0 immediately, and a subsequent ACC_RD returns 0xFFFFFFFF.
